// File: rtl/t02_mem_pkg.sv
// t02_mem_pkg: shared types and helpers for the memory arbiter slice.
package t02_mem_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} mem_arb_state_t;
   localparam int MODE_FIXED = 0;
   localparam int MODE_RR = 1;
   function automatic int idx_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/t02_rr_picker.sv
// t02_rr_picker: combinational winner selection, fixed (lowest index) or round-robin after ptr.
module t02_rr_picker import t02_mem_pkg::*; #(
   parameter int NUM_REQ = 2,
   parameter int RR_MODE = MODE_RR,
   localparam int PW = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid_i,
   input  logic [PW-1:0]      ptr_i,
   output logic [PW-1:0]      idx_o,
   output logic               valid_o
);
   logic [NUM_REQ-1:0] hi, src;
   // Requests above the pointer take precedence; otherwise wrap to the lowest index.
   always_comb begin
      hi = '0;
      for (int j = 0; j < NUM_REQ; j++) hi[j] = req_valid_i[j] && RR_MODE == MODE_RR && PW'(j) > ptr_i;
      src = |hi ? hi : req_valid_i;
      idx_o = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) if (src[j]) idx_o = PW'(j);
   end
   assign valid_o = |req_valid_i;
endmodule

// File: rtl/t02_mem_arbiter.sv
// t02_mem_arbiter: arbitrates NUM_REQ clients onto one RAM bus with per-client responses
// and a bus-busy timeout that completes the transfer with rsp_err set.
module t02_mem_arbiter import t02_mem_pkg::*; #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int RR_MODE = MODE_RR,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_err,
   output logic [ADDR_W-1:0]         ramaddr,
   output logic [DATA_W-1:0]         ramstore,
   output logic                      Ren,
   output logic                      Wen,
   input  logic [DATA_W-1:0]         ramload,
   input  logic                      busy_o
);
   localparam int PW = idx_w(NUM_REQ);
   localparam int CW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
   mem_arb_state_t state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d, sel_addr;
   logic [DATA_W-1:0] wdata_q, wdata_d, sel_wdata, rdata_q, rdata_d;
   logic wr_q, wr_d, sel_wr, err_q, err_d, win_v, grant;
   logic [PW-1:0] owner_q, owner_d, ptr_q, ptr_d, win;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

   t02_rr_picker #(.NUM_REQ(NUM_REQ), .RR_MODE(RR_MODE)) u_picker (
      .req_valid_i(req_valid),
      .ptr_i      (ptr_q),
      .idx_o      (win),
      .valid_o    (win_v)
   );

   // Gated by rst so no grant pulse leaks out while reset holds the FSM in IDLE.
   assign grant = state_q == IDLE && enable && win_v && !rst;
   assign cnt_inc = &cnt_q ? cnt_q : cnt_q + CW'(1);

   always_comb begin
      sel_addr = '0;
      sel_wdata = '0;
      sel_wr = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) if (win == PW'(j)) begin
         sel_addr = req_addr[j*ADDR_W +: ADDR_W];
         sel_wdata = req_wdata[j*DATA_W +: DATA_W];
         sel_wr = req_write[j];
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d = addr_q;
      wdata_d = wdata_q;
      wr_d = wr_q;
      owner_d = owner_q;
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      rdata_d = rdata_q;
      err_d = err_q;
      case (state_q)
         IDLE: if (grant) begin
            addr_d = sel_addr;
            wdata_d = sel_wdata;
            wr_d = sel_wr;
            owner_d = win;
            ptr_d = RR_MODE == MODE_RR ? win : ptr_q;
            state_d = ISSUE;
         end
         ISSUE: begin
            cnt_d = '0;
            state_d = WAIT;
         end
         WAIT: if (!busy_o) begin
            rdata_d = wr_q ? rdata_q : ramload;
            state_d = RESP;
         end else begin
            cnt_d = cnt_inc;
            if (TIMEOUT_CYC != 0 && cnt_inc == CW'(TIMEOUT_CYC)) begin
               err_d = 1'b1;
               rdata_d = '0;
               state_d = RESP;
            end
         end
         RESP: begin
            err_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q <= '0;
         wdata_q <= '0;
         wr_q <= 1'b0;
         owner_q <= '0;
         ptr_q <= PW'(NUM_REQ - 1);
         cnt_q <= '0;
         rdata_q <= '0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         wr_q <= wr_d;
         owner_q <= owner_d;
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         rdata_q <= rdata_d;
         err_q <= err_d;
      end
   end

   assign req_ready = grant ? NUM_REQ'(1) << win : '0;
   assign rsp_valid = state_q == RESP ? NUM_REQ'(1) << owner_q : '0;
   assign Ren = state_q == ISSUE && !wr_q;
   assign Wen = state_q == ISSUE && wr_q;
   assign ramaddr = addr_q;
   assign ramstore = wdata_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err = err_q;
endmodule

// File: tb/tb_t02_mem_arbiter.sv
// tb_t02_mem_arbiter: directed vectors for a 2-client arbiter (timeout 4) and
// 4-client round-robin / fixed-priority instances driven with identical stimulus.
module tb_t02_mem_arbiter;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;

   logic en, busy, ren, wen, err;
   logic [1:0] rv, rw, rdy, rspv;
   logic [63:0] ra, rwd;
   logic [31:0] load, rdata, addr, store;

   logic en4, busy4;
   logic [3:0] rv4, rw4, rr_rdy, rr_rspv, fx_rdy, fx_rspv;
   logic [127:0] ra4, rwd4;
   logic [31:0] load4, rr_rdata, rr_addr, rr_store, fx_rdata, fx_addr, fx_store;
   logic rr_err, rr_ren, rr_wen, fx_err, fx_ren, fx_wen;

   t02_mem_arbiter #(.NUM_REQ(2), .TIMEOUT_CYC(4)) u_dut (
      .clk(clk), .rst(rst), .enable(en), .req_valid(rv), .req_write(rw), .req_addr(ra),
      .req_wdata(rwd), .req_ready(rdy), .rsp_valid(rspv), .rsp_rdata(rdata), .rsp_err(err),
      .ramaddr(addr), .ramstore(store), .Ren(ren), .Wen(wen), .ramload(load), .busy_o(busy)
   );

   t02_mem_arbiter #(.NUM_REQ(4), .RR_MODE(1)) u_rr4 (
      .clk(clk), .rst(rst), .enable(en4), .req_valid(rv4), .req_write(rw4), .req_addr(ra4),
      .req_wdata(rwd4), .req_ready(rr_rdy), .rsp_valid(rr_rspv), .rsp_rdata(rr_rdata), .rsp_err(rr_err),
      .ramaddr(rr_addr), .ramstore(rr_store), .Ren(rr_ren), .Wen(rr_wen), .ramload(load4), .busy_o(busy4)
   );

   t02_mem_arbiter #(.NUM_REQ(4), .RR_MODE(0)) u_fx4 (
      .clk(clk), .rst(rst), .enable(en4), .req_valid(rv4), .req_write(rw4), .req_addr(ra4),
      .req_wdata(rwd4), .req_ready(fx_rdy), .rsp_valid(fx_rspv), .rsp_rdata(fx_rdata), .rsp_err(fx_err),
      .ramaddr(fx_addr), .ramstore(fx_store), .Ren(fx_ren), .Wen(fx_wen), .ramload(load4), .busy_o(busy4)
   );

   int n_chk = 0, n_err = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] rr_seq [5];
   logic [3:0] fx_seq [5];
   logic [3:0] rr_exp [5];
   int nr, nf;

   initial begin
      en = 0; rv = 0; rw = 0; ra = 0; rwd = 0; busy = 0; load = 0;
      en4 = 0; rv4 = 0; rw4 = 0; ra4 = 0; rwd4 = 0; busy4 = 0; load4 = 0;
      rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int i = 0; i < 5; i++) begin
         rr_seq[i] = 0;
         fx_seq[i] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      check("rst_ren", ren, 0);
      check("rst_wen", wen, 0);
      check("rst_rdy", rdy, 0);
      check("rst_rspv", rspv, 0);
      check("rst_err", err, 0);
      check("rst_addr", addr, 0);
      check("rst_store", store, 0);
      check("rst_rdata", rdata, 0);
      rst = 0;

      // single read, client 1, two busy WAIT cycles
      en = 1; rv = 2'b10; ra[63:32] = 32'h40; load = 32'hDEAD_BEEF; #1;
      check("rd_grant", rdy, 2'b10);
      step(); rv = 0; busy = 1; #1;
      check("rd_ren", ren, 1);
      check("rd_wen", wen, 0);
      check("rd_addr", addr, 32'h40);
      step();
      check("rd_ren_once", ren, 0);
      step();
      step(); busy = 0; #1;
      check("rd_rspv_early", rspv, 0);
      step();
      check("rd_rspv", rspv, 2'b10);
      check("rd_rdata", rdata, 32'hDEAD_BEEF);
      check("rd_err", err, 0);
      step();
      check("rd_rspv_pulse", rspv, 0);

      // write, client 0, bus free immediately
      rv = 2'b01; rw = 2'b01; ra[31:0] = 32'h80; rwd[31:0] = 32'h1234_5678; #1;
      check("wr_grant", rdy, 2'b01);
      step(); rv = 0; rw = 0; #1;
      check("wr_wen", wen, 1);
      check("wr_ren", ren, 0);
      check("wr_addr", addr, 32'h80);
      check("wr_store", store, 32'h1234_5678);
      step();
      check("wr_wen_once", wen, 0);
      check("wr_addr_hold", addr, 32'h80);
      step();
      check("wr_rspv", rspv, 2'b01);
      check("wr_rdata_keep", rdata, 32'hDEAD_BEEF);
      step();

      // timeout: busy stuck high for client 0
      rv = 2'b01; ra[31:0] = 32'h100; busy = 1; #1;
      check("to_grant", rdy, 2'b01);
      step(); rv = 0;
      repeat (4) step();
      check("to_rspv_early", rspv, 0);
      step();
      check("to_rspv", rspv, 2'b01);
      check("to_err", err, 1);
      check("to_rdata", rdata, 0);
      step();
      check("to_err_clr", err, 0);
      check("to_rspv_pulse", rspv, 0);
      busy = 0; rv = 2'b10; ra[63:32] = 32'h44; load = 32'hCAFE_F00D; #1;
      check("after_to_grant", rdy, 2'b10);
      step(); rv = 0;
      step();
      step();
      check("after_to_rspv", rspv, 2'b10);
      check("after_to_rdata", rdata, 32'hCAFE_F00D);
      check("after_to_err", err, 0);
      step();

      // enable low blocks grants, dropping it mid-transfer does not
      en = 0; rv = 2'b01; ra[31:0] = 32'h300; #1;
      check("en0_rdy", rdy, 0);
      step();
      check("en0_rdy2", rdy, 0);
      check("en0_ren", ren, 0);
      en = 1; #1;
      check("en1_grant", rdy, 2'b01);
      step(); rv = 0; busy = 1;
      step(); en = 0;
      step(); busy = 0;
      step();
      check("en_drop_rspv", rspv, 2'b01);
      step(); en = 1;

      // async reset while in WAIT; ptr would otherwise favour client 1
      rv = 2'b01; ra[31:0] = 32'h200; busy = 1; #1;
      check("ar_grant", rdy, 2'b01);
      step(); rv = 0;
      step();
      #2 rst = 1;
      #1;
      check("ar_ren", ren, 0);
      check("ar_wen", wen, 0);
      check("ar_rspv", rspv, 0);
      check("ar_addr", addr, 0);
      busy = 0;
      step();
      step();
      check("ar_no_rsp", rspv, 0);
      rst = 0; rv = 2'b11; #1;
      check("ar_first_client0", rdy, 2'b01);
      step(); rv = 0;

      // 4 clients, all requesting continuously
      en4 = 1; rv4 = 4'hF;
      nr = 0; nf = 0;
      for (int c = 0; c < 40 && (nr < 5 || nf < 5); c++) begin
         #1;
         if (rr_rdy != 0 && nr < 5) begin
            rr_seq[nr] = rr_rdy;
            nr++;
         end
         if (fx_rdy != 0 && nf < 5) begin
            fx_seq[nf] = fx_rdy;
            nf++;
         end
         step();
      end
      check("rr_count", nr, 5);
      check("fx_count", nf, 5);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("rr_grant%0d", i), rr_seq[i], rr_exp[i]);
         check($sformatf("fx_grant%0d", i), fx_seq[i], 4'b0001);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
